micro_sequencer: RTL

//   Next-address sequencer for the microprogrammed control unit. Owns the microprogram

---
 rtl/micro_sequencer_pkg.sv | 33 +++
 rtl/micro_stack.sv | 61 ++++++
 rtl/micro_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// micro_sequencer_pkg
//   Shared definitions for the microprogram sequencer: opcode encoding of the
//   mi_op field, condition-select codes of the mi_sel field and the number of
//   external condition inputs.
// -----------------------------------------------------------------------------
package micro_sequencer_pkg;

    // Microinstruction opcodes (mi_op)
    typedef enum logic [2:0] {
        OP_CONT  = 3'd0,  // upc+1
        OP_JMP   = 3'd1,  // unconditional jump to mi_addr
        OP_JCOND = 3'd2,  // jump to mi_addr if cond
        OP_WAIT  = 3'd3,  // stall until cond
        OP_CALL  = 3'd4,  // push return address, jump to mi_addr
        OP_RET   = 3'd5,  // jump to popped return address
        OP_LDCNT = 3'd6,  // load loop counter from mi_addr
        OP_DJNZ  = 3'd7   // decrement counter, loop while it was > 1
    } op_e;

    // Condition-select codes (mi_sel)
    localparam logic [2:0] SEL_ALWAYS = 3'd0;
    localparam logic [2:0] SEL_C1     = 3'd1;
    localparam logic [2:0] SEL_C2     = 3'd2;
    localparam logic [2:0] SEL_C3     = 3'd3;
    localparam logic [2:0] SEL_C4     = 3'd4;
    localparam logic [2:0] SEL_C5     = 3'd5;
    localparam logic [2:0] SEL_C6     = 3'd6;
    localparam logic [2:0] SEL_CNTZ   = 3'd7;

    localparam int NUM_COND = 6;

endpackage

// File: rtl/micro_stack.sv
// -----------------------------------------------------------------------------
// micro_stack
//   DEPTH x WIDTH LIFO holding microprogram return addresses.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   synchronous active-low reset (empties the stack)
//     push   in   write din on top (ignored when full)
//     pop    in   discard top entry (ignored when empty)
//     din    in   WIDTH  value to push
//     top    out  WIDTH  current top-of-stack entry (undefined when empty)
//     full   out  no free entry
//     empty  out  no valid entry
// -----------------------------------------------------------------------------
module micro_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SP_W  = $clog2(DEPTH + 1);

    logic [SP_W-1:0]  sp_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] top_idx;

    assign full    = (sp_q == SP_W'(DEPTH));
    assign empty   = (sp_q == '0);
    assign top_idx = IDX_W'(sp_q - SP_W'(1));
    assign top     = mem_q[top_idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; only sp_q decides
    // which entries are valid, and leaving the array reset-free lets it map to
    // plain registers/RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (rst && push && !full) begin
            mem_q[sp_q[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//   Next-address sequencer for a microprogrammed control unit. Holds the
//   microprogram counter, a return stack, a loop counter and the output latch.
//   The control ROM is external and combinational: the microinstruction at upc
//   executes in the current cycle, its effects appear after the next edge.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-low reset
//     condicion  in   6       external conditions C1..C6 (bit0 = C1)
//     mi_op      in   3       opcode (see op_e)
//     mi_sel     in   3       condition select
//     mi_pol     in   1       invert selected condition
//     mi_addr    in   ADDR_W  branch target / loop count
//     mi_out_we  in   1       load mi_out into salida
//     mi_out     in   OUT_W   output pattern
//     upc        out  ADDR_W  current microaddress
//     salida     out  OUT_W   registered outputs
//     stack_err  out  1       sticky CALL-on-full / RET-on-empty flag
// -----------------------------------------------------------------------------
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4,
    parameter int OUT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COND-1:0] condicion,
    input  logic [2:0]          mi_op,
    input  logic [2:0]          mi_sel,
    input  logic                mi_pol,
    input  logic [ADDR_W-1:0]   mi_addr,
    input  logic                mi_out_we,
    input  logic [OUT_W-1:0]    mi_out,
    output logic [ADDR_W-1:0]   upc,
    output logic [OUT_W-1:0]    salida,
    output logic                stack_err
);

    logic [ADDR_W-1:0]   upc_q, upc_d, upc_inc;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [NUM_COND-1:0] cond_q;
    logic [OUT_W-1:0]    salida_q;
    logic                stack_err_q;
    logic                err_set;
    logic                cond_raw, cond;

    logic                stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0]   stk_top;

    micro_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (upc_inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign upc_inc = upc_q + ADDR_W'(1);

    // Condition select: uses the registered conditions and the counter value
    // before any update made by this cycle's instruction.
    always_comb begin
        cond_raw = 1'b1;
        case (mi_sel)
            SEL_ALWAYS: cond_raw = 1'b1;
            SEL_CNTZ:   cond_raw = (cnt_q == '0);
            default:    cond_raw = cond_q[mi_sel - 3'd1];
        endcase
        cond = cond_raw ^ mi_pol;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        upc_d    = upc_inc;
        cnt_d    = cnt_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        err_set  = 1'b0;
        case (op_e'(mi_op))
            OP_CONT:  upc_d = upc_inc;
            OP_JMP:   upc_d = mi_addr;
            OP_JCOND: upc_d = cond ? mi_addr : upc_inc;
            OP_WAIT:  upc_d = cond ? upc_inc : upc_q;
            OP_CALL: begin
                if (stk_full) begin
                    err_set = 1'b1;
                end else begin
                    stk_push = 1'b1;
                    upc_d    = mi_addr;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    err_set = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                    upc_d   = stk_top;
                end
            end
            OP_LDCNT: cnt_d = mi_addr;
            OP_DJNZ: begin
                // Loop while the pre-decrement count exceeds 1: N loads give N
                // body passes, and a zero load still gives one pass.
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - ADDR_W'(1);
                upc_d = (cnt_q > ADDR_W'(1)) ? mi_addr : upc_inc;
            end
            default: upc_d = upc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            upc_q       <= '0;
            cnt_q       <= '0;
            cond_q      <= '0;
            salida_q    <= '0;
            stack_err_q <= 1'b0;
        end else begin
            upc_q  <= upc_d;
            cnt_q  <= cnt_d;
            cond_q <= condicion;
            if (mi_out_we) begin
                salida_q <= mi_out;
            end
            if (err_set) begin
                stack_err_q <= 1'b1;
            end
        end
    end

    assign upc       = upc_q;
    assign salida    = salida_q;
    assign stack_err = stack_err_q;

endmodule
